clk_div_ctrl: RTL and testbench

Run-time controller for the divide-by-N clock-enable path. It generates the divided output `po_cnt`. Divide ratio changes and start/stop requests are applied only at period boundaries, so no truncated or runt pulses occur. It sits between the configuration/control logic and the blocks that consume the divided clock, and replaces the fixed divide-by-4 instance wherever a programmable ratio is needed.

---
 rtl/clk_div_pkg.sv | 24 ++
 rtl/clk_div_ctrl_if.sv | 31 +++
 rtl/clk_div_core.sv | 68 ++++++
 rtl/clk_div_ctrl.sv | 134 +++++++++++++
 tb/tb_clk_div_ctrl.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/clk_div_pkg.sv
// ---------------------------------------------------------------------------
// clk_div_pkg
// Shared definitions for the programmable clock-enable divider:
//   - state_t : controller states (stopped, running, ratio change pending)
//   - DIV_MIN : smallest ratio the divider can produce
//   - half()  : length of the high phase for a given ratio
// ---------------------------------------------------------------------------
package clk_div_pkg;

    typedef enum logic [1:0] {
        ST_STOP   = 2'd0,
        ST_RUN    = 2'd1,
        ST_SWITCH = 2'd2
    } state_t;

    localparam int DIV_MIN = 2;

    // The high phase is the lower half of the period; for odd ratios the
    // extra cycle lands in the low phase.
    function automatic int unsigned half(input int unsigned n);
        return n >> 1;
    endfunction

endpackage

// File: rtl/clk_div_ctrl_if.sv
// ---------------------------------------------------------------------------
// clk_div_ctrl_if
// Ratio configuration handshake between the control logic (master) and the
// divider controller (slave).
//   cfg_valid : master offers a new ratio
//   cfg_div   : requested ratio N
//   cfg_ready : controller can accept a ratio this cycle
//   cfg_err   : one-cycle pulse, the accepted ratio was illegal
// ---------------------------------------------------------------------------
interface clk_div_ctrl_if #(
    parameter int DIV_W = 8
);
    logic             cfg_valid;
    logic [DIV_W-1:0] cfg_div;
    logic             cfg_ready;
    logic             cfg_err;

    modport master (
        output cfg_valid,
        output cfg_div,
        input  cfg_ready,
        input  cfg_err
    );

    modport slave (
        input  cfg_valid,
        input  cfg_div,
        output cfg_ready,
        output cfg_err
    );
endinterface

// File: rtl/clk_div_core.sv
// ---------------------------------------------------------------------------
// clk_div_core
// Period counter and output flops of the divider.
//   clk, rst   : system clock, synchronous active-high reset
//   active_i   : divider is running in the current cycle
//   run_i      : divider will be running in the next cycle
//   load_i     : restart the period at zero on this edge
//   n_i        : ratio in effect for the current cycle
//   n_next_i   : ratio in effect from the next cycle on
//   wrap_o     : current cycle is the last one of the period
//   po_cnt_o   : divided output, straight from a flop
//   po_tick_o  : pulse on the first cycle of each period
// ---------------------------------------------------------------------------
module clk_div_core
    import clk_div_pkg::*;
#(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             active_i,
    input  logic             run_i,
    input  logic             load_i,
    input  logic [DIV_W-1:0] n_i,
    input  logic [DIV_W-1:0] n_next_i,
    output logic             wrap_o,
    output logic             po_cnt_o,
    output logic             po_tick_o
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;
    logic [DIV_W-1:0] halfN;
    logic             po_cnt_q;
    logic             po_cnt_d;
    logic             po_tick_q;
    logic             po_tick_d;

    assign wrap_o = active_i && (cnt_q == (n_i - DIV_W'(1)));

    // The outputs are computed from the counter value and ratio of the
    // coming cycle so that they can be registered without a cycle of lag.
    always_comb begin
        cnt_d = '0;
        if (run_i && !load_i && !wrap_o) begin
            cnt_d = cnt_q + DIV_W'(1);
        end
        halfN     = DIV_W'(half(32'(n_next_i)));
        po_cnt_d  = run_i && (cnt_d < halfN);
        po_tick_d = run_i && (cnt_d == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            po_cnt_q  <= 1'b0;
            po_tick_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            po_cnt_q  <= po_cnt_d;
            po_tick_q <= po_tick_d;
        end
    end

    assign po_cnt_o  = po_cnt_q;
    assign po_tick_o = po_tick_q;

endmodule

// File: rtl/clk_div_ctrl.sv
// ---------------------------------------------------------------------------
// clk_div_ctrl
// Run-time controller for the divide-by-N clock-enable path. Ratio changes
// and start/stop requests take effect only at period boundaries.
//   clk, rst  : system clock, synchronous active-high reset
//   en        : run request, level sensitive, acted on at period ends
//   cfg       : ratio handshake (slave side of clk_div_ctrl_if)
//   po_cnt    : divided output
//   po_tick   : pulse on the first cycle of each period
//   active    : divider running or switching ratio
// ---------------------------------------------------------------------------
module clk_div_ctrl
    import clk_div_pkg::*;
#(
    parameter int DIV_W   = 8,
    parameter int DEF_DIV = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    clk_div_ctrl_if.slave        cfg,
    output logic                 po_cnt,
    output logic                 po_tick,
    output logic                 active
);

    generate
        if (DEF_DIV < DIV_MIN || DEF_DIV > (2 ** DIV_W) - 1) begin : g_bad_def_div
            $error("clk_div_ctrl: DEF_DIV outside 2 .. 2^DIV_W-1");
        end
    endgenerate

    state_t           state_q;
    state_t           state_d;
    logic [DIV_W-1:0] n_q;
    logic [DIV_W-1:0] n_d;
    logic [DIV_W-1:0] shadow_q;
    logic [DIV_W-1:0] shadow_d;
    logic             err_q;
    logic             err_d;

    logic             xfer;
    logic             legal;
    logic             xferOk;
    logic             wrap;
    logic             runNext;
    logic             load;

    assign xfer   = cfg.cfg_valid && cfg.cfg_ready;
    assign legal  = cfg.cfg_div >= DIV_W'(DIV_MIN);
    assign xferOk = xfer && legal;

    // State, ratio, shadow and error registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_STOP;
            n_q      <= DIV_W'(DEF_DIV);
            shadow_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            n_q      <= n_d;
            shadow_q <= shadow_d;
            err_q    <= err_d;
        end
    end

    // A ratio arriving mid-period waits in the shadow register until the
    // wrap edge; one arriving exactly on the wrap edge needs no waiting.
    always_comb begin
        state_d  = state_q;
        n_d      = n_q;
        shadow_d = shadow_q;
        err_d    = xfer && !legal;
        case (state_q)
            ST_STOP: begin
                if (xferOk) begin
                    n_d = cfg.cfg_div;
                end
                if (en) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (wrap) begin
                    if (xferOk) begin
                        n_d = cfg.cfg_div;
                    end
                    if (!en) begin
                        state_d = ST_STOP;
                    end
                end else if (xferOk) begin
                    shadow_d = cfg.cfg_div;
                    state_d  = ST_SWITCH;
                end
            end
            ST_SWITCH: begin
                if (wrap) begin
                    n_d     = shadow_q;
                    state_d = en ? ST_RUN : ST_STOP;
                end
            end
            default: begin
                state_d = ST_STOP;
            end
        endcase
    end

    // Status outputs and core controls derived from the state.
    always_comb begin
        cfg.cfg_ready = (state_q != ST_SWITCH);
        active        = (state_q != ST_STOP);
        load          = (state_q == ST_STOP);
        runNext       = (state_d != ST_STOP);
    end

    assign cfg.cfg_err = err_q;

    clk_div_core #(
        .DIV_W(DIV_W)
    ) u_core (
        .clk       (clk),
        .rst       (rst),
        .active_i  (active),
        .run_i     (runNext),
        .load_i    (load),
        .n_i       (n_q),
        .n_next_i  (n_d),
        .wrap_o    (wrap),
        .po_cnt_o  (po_cnt),
        .po_tick_o (po_tick)
    );

endmodule

// File: tb/tb_clk_div_ctrl.sv
// ---------------------------------------------------------------------------
// tb_clk_div_ctrl
// Directed bench for clk_div_ctrl with a period-level reference model that is
// compared against the outputs on every cycle, plus literal expectations for
// each scenario.
// ---------------------------------------------------------------------------
module tb_clk_div_ctrl;

    localparam int DIV_W   = 8;
    localparam int DEF_DIV = 4;

    logic clk;
    logic rst;
    logic en;
    logic po_cnt;
    logic po_tick;
    logic active;

    int checks = 0;
    int errors = 0;

    clk_div_ctrl_if #(.DIV_W(DIV_W)) cfgIf ();

    clk_div_ctrl #(
        .DIV_W  (DIV_W),
        .DEF_DIV(DEF_DIV)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .cfg    (cfgIf),
        .po_cnt (po_cnt),
        .po_tick(po_tick),
        .active (active)
    );

    // 20 ns clock period.
    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Reference model: the divider as "running or not", the ratio in force,
    // the position inside the current period and a pending ratio.
    bit modelLive = 1'b0;
    bit mRun;
    bit mPend;
    bit mErr;
    int mN;
    int mShadow;
    int mPos;

    always @(posedge clk) begin
        int  d;
        bit  take;
        bit  ok;
        bit  endOfPeriod;
        d    = int'(cfgIf.cfg_div);
        take = cfgIf.cfg_valid && !mPend;
        ok   = take && (d >= 2);
        if (rst) begin
            mRun    = 1'b0;
            mPend   = 1'b0;
            mErr    = 1'b0;
            mN      = DEF_DIV;
            mShadow = 0;
            mPos    = 0;
        end else begin
            mErr = take && !ok;
            if (!mRun) begin
                if (ok) mN = d;
                if (en) begin
                    mRun = 1'b1;
                    mPos = 0;
                end
            end else begin
                endOfPeriod = (mPos == mN - 1);
                if (endOfPeriod) begin
                    if (mPend) begin
                        mN    = mShadow;
                        mPend = 1'b0;
                    end else if (ok) begin
                        mN = d;
                    end
                    mPos = 0;
                    if (!en) mRun = 1'b0;
                end else begin
                    mPos = mPos + 1;
                    if (ok) begin
                        mShadow = d;
                        mPend   = 1'b1;
                    end
                end
            end
        end
        modelLive = 1'b1;
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d time=%0t", name, actual, expected, $time);
        end
    endtask

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (modelLive) begin
            checkOutput("model.po_cnt",    int'(po_cnt),          int'(mRun && (mPos < (mN / 2))));
            checkOutput("model.po_tick",   int'(po_tick),         int'(mRun && (mPos == 0)));
            checkOutput("model.active",    int'(active),          int'(mRun));
            checkOutput("model.cfg_ready", int'(cfgIf.cfg_ready), int'(!mPend));
            checkOutput("model.cfg_err",   int'(cfgIf.cfg_err),   int'(mErr));
        end
    end

    task automatic applyStimulus(input bit r, input bit e, input bit v, input int d);
        rst             = r;
        en              = e;
        cfgIf.cfg_valid = v;
        cfgIf.cfg_div   = DIV_W'(d);
    endtask

    task automatic waitTick();
        int k;
        k = 0;
        @(negedge clk);
        while (!po_tick && k < 50) begin
            @(negedge clk);
            k++;
        end
        checkOutput("tick.timeout", int'(po_tick), 1);
    endtask

    task automatic measurePeriod(input string name, input int expected);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!po_tick && k < 50);
        checkOutput(name, k, expected);
    endtask

    initial begin
        int expPo[];
        int expTick[];
        int expReady[];

        // Watchdog so the run always ends.
        fork
            begin
                #200000;
                $display("[TB] FAIL watchdog actual=timeout expected=finish");
                $fatal(1, "[TB] watchdog expired");
            end
        join_none

        // Reset for 50 ns.
        applyStimulus(1'b1, 1'b0, 1'b0, 0);
        #50;
        @(negedge clk);
        checkOutput("reset.po_cnt",    int'(po_cnt), 0);
        checkOutput("reset.active",    int'(active), 0);
        checkOutput("reset.cfg_ready", int'(cfgIf.cfg_ready), 1);

        // Default ratio of 4.
        applyStimulus(1'b0, 1'b1, 1'b0, 0);
        expPo   = '{1, 1, 0, 0, 1, 1, 0, 0};
        expTick = '{1, 0, 0, 0, 1, 0, 0, 0};
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checkOutput("div4.po_cnt",  int'(po_cnt),  expPo[i]);
            checkOutput("div4.po_tick", int'(po_tick), expTick[i]);
        end

        // Ratio change to 6 requested at cnt=1.
        waitTick();
        @(negedge clk);
        applyStimulus(1'b0, 1'b1, 1'b1, 6);
        expPo    = '{0, 0, 1, 1, 1, 0, 0, 0, 1, 1, 1, 0, 0, 0};
        expTick  = '{0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0};
        expReady = '{0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            checkOutput("switch6.po_cnt",    int'(po_cnt),          expPo[i]);
            checkOutput("switch6.po_tick",   int'(po_tick),         expTick[i]);
            checkOutput("switch6.cfg_ready", int'(cfgIf.cfg_ready), expReady[i]);
            if (i == 0) applyStimulus(1'b0, 1'b1, 1'b0, 0);
        end

        // Illegal ratio 1 while running.
        applyStimulus(1'b0, 1'b1, 1'b1, 1);
        @(negedge clk);
        checkOutput("illegal.cfg_err.pulse", int'(cfgIf.cfg_err), 1);
        applyStimulus(1'b0, 1'b1, 1'b0, 0);
        @(negedge clk);
        checkOutput("illegal.cfg_err.end", int'(cfgIf.cfg_err), 0);
        checkOutput("illegal.active",      int'(active), 1);
        waitTick();
        measurePeriod("illegal.period", 6);

        // Back to 4 for the stop test.
        applyStimulus(1'b0, 1'b1, 1'b1, 4);
        @(negedge clk);
        checkOutput("back4.cfg_ready", int'(cfgIf.cfg_ready), 0);
        applyStimulus(1'b0, 1'b1, 1'b0, 0);
        waitTick();
        measurePeriod("back4.period", 4);

        // Stop requested at cnt=1: period completes, then stopped.
        @(negedge clk);
        checkOutput("stop.high", int'(po_cnt), 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checkOutput("stop.tail.po_cnt", int'(po_cnt), 0);
            checkOutput("stop.tail.active", int'(active), 1);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("stop.idle.active", int'(active), 0);
            checkOutput("stop.idle.po_cnt", int'(po_cnt), 0);
        end

        // Odd ratio 5 loaded while stopped, then run.
        applyStimulus(1'b0, 1'b0, 1'b1, 5);
        @(negedge clk);
        applyStimulus(1'b0, 1'b1, 1'b0, 0);
        expPo   = '{1, 1, 0, 0, 0, 1, 1, 0, 0, 0};
        expTick = '{1, 0, 0, 0, 0, 1, 0, 0, 0, 0};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("div5.po_cnt",  int'(po_cnt),  expPo[i]);
            checkOutput("div5.po_tick", int'(po_tick), expTick[i]);
        end

        // Reset while a change to 7 is pending.
        waitTick();
        @(negedge clk);
        applyStimulus(1'b0, 1'b1, 1'b1, 7);
        @(negedge clk);
        checkOutput("rstsw.pending", int'(cfgIf.cfg_ready), 0);
        applyStimulus(1'b1, 1'b1, 1'b0, 0);
        @(negedge clk);
        checkOutput("rstsw.po_cnt",    int'(po_cnt),          0);
        checkOutput("rstsw.po_tick",   int'(po_tick),         0);
        checkOutput("rstsw.active",    int'(active),          0);
        checkOutput("rstsw.cfg_err",   int'(cfgIf.cfg_err),   0);
        checkOutput("rstsw.cfg_ready", int'(cfgIf.cfg_ready), 1);
        applyStimulus(1'b0, 1'b1, 1'b0, 0);
        expPo = '{1, 1, 0, 0, 1, 1, 0, 0};
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checkOutput("rstsw.div4.po_cnt", int'(po_cnt), expPo[i]);
        end

        // Stop and a new ratio of 3 on the same wrap edge.
        waitTick();
        repeat (3) @(negedge clk);
        applyStimulus(1'b0, 1'b0, 1'b1, 3);
        @(negedge clk);
        checkOutput("wrapstop.active", int'(active), 0);
        applyStimulus(1'b0, 1'b1, 1'b0, 0);
        expPo   = '{1, 0, 0, 1, 0, 0};
        expTick = '{1, 0, 0, 1, 0, 0};
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checkOutput("div3.po_cnt",  int'(po_cnt),  expPo[i]);
            checkOutput("div3.po_tick", int'(po_tick), expTick[i]);
        end

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
